gtp_rx_link_monitor: RTL and testbench

GTP_RX_LINK_MONITOR -- requirements
Module: gtp_rx_link_monitor

---
 rtl/gtp_rx_link_monitor.sv | 176 +++++++++++++++++
 tb/tb_gtp_rx_link_monitor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gtp_rx_link_monitor.sv
// gtp_rx_link_monitor
// Comma-based byte alignment and link-health monitor for a 2-byte GTP RX
// interface. Hunts for a K28.5 comma (8'hBC with K set), verifies it at a
// fixed lane, then declares lock. It drops lock on accumulated errors and
// realigns the output stream to the selected comma lane.
//
// Ports
//   clk            rx user clock, rising edge
//   rst_n          asynchronous active-low reset
//   rx_en          transceiver RX reset done; when low, words are ignored
//   rx_data        decoded 16-bit word, byte0 = [7:0]
//   rx_charisk     per-byte K flag
//   rx_disperr     per-byte disparity error
//   rx_notintable  per-byte code violation
//   data_out       byte-aligned data, 2-cycle latency
//   charisk_out    byte-aligned K flags, 2-cycle latency
//   data_valid     data_out qualifier (words accepted while locked)
//   link_up        FSM is in LOCKED
//   lane_offset    selected comma lane
//   err_total      saturating count of error words
module gtp_rx_link_monitor #(
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned ERR_LIMIT  = 4,
   parameter int unsigned GOOD_RUN   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_en,
   input  logic [15:0] rx_data,
   input  logic [1:0]  rx_charisk,
   input  logic [1:0]  rx_disperr,
   input  logic [1:0]  rx_notintable,
   output logic [15:0] data_out,
   output logic [1:0]  charisk_out,
   output logic        data_valid,
   output logic        link_up,
   output logic        lane_offset,
   output logic [15:0] err_total
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);
   localparam logic [7:0] RUN_N  = 8'(GOOD_RUN);

   state_t      state;
   logic [3:0]  good_cnt;
   logic [3:0]  err_acc;
   logic [7:0]  run_cnt;

   logic [1:0]  comma_lane;
   logic        code_err;
   logic        own_comma;
   logic        other_comma;
   logic        err_word;

   logic [15:0] s1_data;
   logic [1:0]  s1_k;
   logic        s1_valid;
   logic [7:0]  prev_hi;
   logic        prev_k_hi;

   always_comb begin
      comma_lane[0] = rx_charisk[0] && (rx_data[7:0]  == 8'hBC);
      comma_lane[1] = rx_charisk[1] && (rx_data[15:8] == 8'hBC);
      code_err      = rx_en && ((rx_disperr | rx_notintable) != 2'b00);
      own_comma     = lane_offset ? comma_lane[1] : comma_lane[0];
      other_comma   = lane_offset ? comma_lane[0] : comma_lane[1];
      // A comma outside the selected lane means alignment is wrong once committed.
      err_word      = code_err || (rx_en && (state != HUNT) && other_comma);
   end

   // Link FSM; link_up is registered alongside the state it reflects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         good_cnt    <= '0;
         err_acc     <= '0;
         run_cnt     <= '0;
         lane_offset <= 1'b0;
         link_up     <= 1'b0;
      end else if (!rx_en) begin
         state    <= HUNT;
         good_cnt <= '0;
         err_acc  <= '0;
         run_cnt  <= '0;
         link_up  <= 1'b0;
      end else begin
         case (state)
            HUNT: begin
               if (comma_lane != 2'b00) begin
                  lane_offset <= !comma_lane[0];   // lane 0 wins a tie
                  good_cnt    <= 4'd1;
                  if (LOCK_N == 4'd1) begin
                     state   <= LOCKED;
                     link_up <= 1'b1;
                  end else begin
                     state <= VERIFY;
                  end
               end
            end
            VERIFY: begin
               if (err_word) begin
                  state    <= HUNT;
                  good_cnt <= '0;
               end else if (own_comma) begin
                  good_cnt <= good_cnt + 4'd1;
                  if (good_cnt + 4'd1 == LOCK_N) begin
                     state   <= LOCKED;
                     link_up <= 1'b1;
                  end
               end
            end
            LOCKED: begin
               if (err_word) begin
                  run_cnt <= '0;
                  if (err_acc + 4'd1 == ERR_N) begin
                     state    <= HUNT;
                     link_up  <= 1'b0;
                     err_acc  <= '0;
                     good_cnt <= '0;
                  end else begin
                     err_acc <= err_acc + 4'd1;
                  end
               end else if (run_cnt + 8'd1 == RUN_N) begin
                  run_cnt <= '0;
                  err_acc <= '0;
               end else begin
                  run_cnt <= run_cnt + 8'd1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_total <= '0;
      end else if (err_word && (err_total != '1)) begin
         err_total <= err_total + 16'd1;
      end
   end

   // Two-stage alignment pipe: stage 1 captures the word, stage 2 muxes it
   // with the upper byte of the word before it. Offset 0 passes through the
   // same two registers so both offsets share the same latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data     <= '0;
         s1_k        <= '0;
         s1_valid    <= 1'b0;
         prev_hi     <= '0;
         prev_k_hi   <= 1'b0;
         data_out    <= '0;
         charisk_out <= '0;
         data_valid  <= 1'b0;
      end else begin
         s1_data   <= rx_data;
         s1_k      <= rx_charisk;
         s1_valid  <= rx_en && (state == LOCKED);
         prev_hi   <= s1_data[15:8];
         prev_k_hi <= s1_k[1];
         if (lane_offset) begin
            data_out    <= {s1_data[7:0], prev_hi};
            charisk_out <= {s1_k[0], prev_k_hi};
         end else begin
            data_out    <= s1_data;
            charisk_out <= s1_k;
         end
         data_valid <= s1_valid;
      end
   end

endmodule

// File: tb/tb_gtp_rx_link_monitor.sv
// Scoreboard bench for gtp_rx_link_monitor: the driver steps a behavioural
// model per accepted word and queues expected aligned output; a negedge
// monitor compares status every cycle and pops on data_valid.
module tb_gtp_rx_link_monitor;

   localparam int LOCK_C = 4;
   localparam int ERR_C  = 4;
   localparam int RUN_C  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx_en = 1'b0;
   logic [15:0] rx_data = '0;
   logic [1:0]  rx_charisk = '0;
   logic [1:0]  rx_disperr = '0;
   logic [1:0]  rx_notintable = '0;
   logic [15:0] data_out;
   logic [1:0]  charisk_out;
   logic        data_valid;
   logic        link_up;
   logic        lane_offset;
   logic [15:0] err_total;

   always #5 clk = ~clk;

   gtp_rx_link_monitor #(
      .LOCK_COUNT(LOCK_C),
      .ERR_LIMIT (ERR_C),
      .GOOD_RUN  (RUN_C)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_en        (rx_en),
      .rx_data      (rx_data),
      .rx_charisk   (rx_charisk),
      .rx_disperr   (rx_disperr),
      .rx_notintable(rx_notintable),
      .data_out     (data_out),
      .charisk_out  (charisk_out),
      .data_valid   (data_valid),
      .link_up      (link_up),
      .lane_offset  (lane_offset),
      .err_total    (err_total)
   );

   typedef struct {
      int unsigned stamp;
      logic [15:0] d;
      logic [1:0]  k;
   } exp_t;
   exp_t sb[$];

   typedef enum {M_HUNT, M_VERIFY, M_LOCKED} mstate_t;
   mstate_t     m_state;
   int          m_good, m_acc, m_run, m_total;
   logic        m_lane;
   logic [15:0] m_prev;
   logic [1:0]  m_prevk;

   int          errors = 0;
   int          checks = 0;
   int unsigned edge_cnt = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
      end
   endfunction

   function automatic void m_hunt();
      m_state = M_HUNT;
      m_good  = 0;
      m_acc   = 0;
      m_run   = 0;
   endfunction

   function automatic void model_reset();
      m_hunt();
      m_total = 0;
      m_lane  = 1'b0;
      m_prev  = '0;
      m_prevk = '0;
      sb.delete();
   endfunction

   function automatic void model_step(logic [15:0] d, logic [1:0] k, logic [1:0] de,
                                      logic [1:0] ni, logic en);
      bit c0, c1, bad;
      exp_t e;
      c0 = k[0] && (d[7:0] == 8'hBC);
      c1 = k[1] && (d[15:8] == 8'hBC);
      if (en && m_state == M_LOCKED) begin
         e.stamp = edge_cnt + 1;
         e.d = m_lane ? {d[7:0], m_prev[15:8]} : d;
         e.k = m_lane ? {k[0], m_prevk[1]} : k;
         sb.push_back(e);
      end
      m_prev  = d;
      m_prevk = k;
      bad = en && (((de | ni) != 2'b00) || (m_state != M_HUNT && (m_lane ? c0 : c1)));
      if (bad && m_total < 65535) m_total++;
      if (!en) begin
         m_hunt();
      end else if (m_state == M_HUNT) begin
         if (c0 || c1) begin
            m_lane  = c0 ? 1'b0 : 1'b1;
            m_good  = 1;
            m_state = (LOCK_C == 1) ? M_LOCKED : M_VERIFY;
         end
      end else if (m_state == M_VERIFY) begin
         if (bad) m_hunt();
         else if (m_lane ? c1 : c0) begin
            m_good++;
            if (m_good == LOCK_C) m_state = M_LOCKED;
         end
      end else begin
         if (bad) begin
            m_acc++;
            m_run = 0;
            if (m_acc == ERR_C) m_hunt();
         end else begin
            m_run++;
            if (m_run == RUN_C) begin
               m_run = 0;
               m_acc = 0;
            end
         end
      end
   endfunction

   task automatic cycle(input logic [15:0] d, input logic [1:0] k, input logic [1:0] de,
                        input logic [1:0] ni, input logic en);
      rx_data       = d;
      rx_charisk    = k;
      rx_disperr    = de;
      rx_notintable = ni;
      rx_en         = en;
      @(posedge clk);
      edge_cnt++;
      model_step(d, k, de, ni, en);
      #1;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) cycle(16'($urandom) & 16'h7F7F, 2'b00, 2'b00, 2'b00, 1'b1);
   endtask

   task automatic lock0();
      for (int i = 0; i < 4; i++) begin
         cycle(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1);
         if (i < 3) clean(1);
      end
   endtask

   always @(negedge clk) begin
      check("link_up", 32'(link_up), 32'(m_state == M_LOCKED));
      check("lane_offset", 32'(lane_offset), 32'(m_lane));
      check("err_total", 32'(err_total), 32'(m_total));
      if (data_valid) begin
         if (sb.size() == 0) begin
            check("spurious_valid", 32'(data_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("valid_latency", edge_cnt, e.stamp);
            check("data_out", 32'(data_out), 32'(e.d));
            check("charisk_out", 32'(charisk_out), 32'(e.k));
         end
      end else if (sb.size() != 0 && sb[0].stamp <= edge_cnt) begin
         check("missing_valid", 32'(data_valid), 32'd1);
         void'(sb.pop_front());
      end
   end

   initial begin
      logic [15:0] t0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_data_out", 32'(data_out), 32'd0);
      rst_n = 1'b1;

      // Lock on lane 0
      lock0();
      check("lock_link_up", 32'(link_up), 32'd1);
      check("lock_lane", 32'(lane_offset), 32'd0);
      clean(6);

      // Lane shift to byte 1
      cycle(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(16'hBC50, 2'b10, 2'b00, 2'b00, 1'b1);
         clean(1);
      end
      cycle(16'h2211, 2'b00, 2'b00, 2'b00, 1'b1);
      cycle(16'h4433, 2'b00, 2'b00, 2'b00, 1'b1);
      cycle(16'h6655, 2'b00, 2'b00, 2'b00, 1'b1);
      check("shift_lane", 32'(lane_offset), 32'd1);
      check("shift_data", 32'(data_out), 32'h3322);
      clean(4);

      // Loss of lock: 4 errors, short clean runs between
      t0 = err_total;
      for (int i = 0; i < 4; i++) begin
         cycle(16'h1111, 2'b00, 2'b01, 2'b00, 1'b1);
         if (i < 3) clean(3);
      end
      check("loss_link_up", 32'(link_up), 32'd0);
      check("loss_err_delta", 32'(err_total - t0), 32'd4);

      // Error recovery: 3 errors, 16 clean, 3 errors
      lock0();
      t0 = err_total;
      for (int i = 0; i < 3; i++) cycle(16'h2222, 2'b00, 2'b00, 2'b10, 1'b1);
      clean(16);
      for (int i = 0; i < 3; i++) cycle(16'h3333, 2'b00, 2'b11, 2'b00, 1'b1);
      check("recover_link_up", 32'(link_up), 32'd1);
      check("recover_err_delta", 32'(err_total - t0), 32'd6);
      clean(16);

      // Both-lane comma in HUNT, then rx_en drop mid-VERIFY
      cycle(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
      cycle(16'hBCBC, 2'b11, 2'b00, 2'b00, 1'b1);
      check("tie_lane", 32'(lane_offset), 32'd0);
      cycle(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1);
      cycle(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) cycle(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1);
      check("verify_restart", 32'(link_up), 32'd0);
      cycle(16'h50BC, 2'b01, 2'b00, 2'b00, 1'b1);
      check("verify_relock", 32'(link_up), 32'd1);
      clean(4);

      // Randomized segments
      for (int seg = 0; seg < 8; seg++) begin
         logic lane;
         lane = 1'($urandom_range(0, 1));
         for (int i = 0; i < 200; i++) begin
            int r;
            logic [15:0] d;
            logic [1:0] k, de, ni;
            logic en;
            r  = $urandom_range(0, 99);
            d  = 16'($urandom);
            k  = 2'b00; de = 2'b00; ni = 2'b00; en = 1'b1;
            if (r < 2) begin
               d = 16'hBCBC; k = 2'b11;
            end else if (r < 20) begin
               if (lane) begin d[15:8] = 8'hBC; k = 2'b10; end
               else begin d[7:0] = 8'hBC; k = 2'b01; end
            end else if (r < 24) begin
               de = 2'($urandom_range(1, 3));
            end else if (r < 26) begin
               ni = 2'($urandom_range(1, 3));
            end else if (r < 27) begin
               en = 1'b0;
            end
            cycle(d, k, de, ni, en);
         end
      end

      // Async reset pulse while locked, then fresh lock
      cycle(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
      lock0();
      clean(3);
      #2 rst_n = 1'b0;
      #1;
      check("arst_link_up", 32'(link_up), 32'd0);
      check("arst_valid", 32'(data_valid), 32'd0);
      check("arst_data", 32'(data_out), 32'd0);
      check("arst_k", 32'(charisk_out), 32'd0);
      check("arst_lane", 32'(lane_offset), 32'd0);
      check("arst_err", 32'(err_total), 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
      lock0();
      check("arst_relock", 32'(link_up), 32'd1);
      clean(4);

      // err_total saturation (HUNT, disparity errors only)
      cycle(16'h0000, 2'b00, 2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 65533; i++) cycle(16'h1234, 2'b00, 2'b01, 2'b00, 1'b1);
      check("sat_pre", 32'(err_total), 32'h0000FFFD);
      for (int i = 0; i < 5; i++) cycle(16'h1234, 2'b00, 2'b10, 2'b00, 1'b1);
      check("sat_hold", 32'(err_total), 32'h0000FFFF);

      clean(4);
      @(negedge clk);
      check("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
